// File: rtl/mem_pkg.sv
// Shared types and address helpers for the line memory responder.
// Holds the FSM state encoding and the line-alignment arithmetic.
package mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StBurst,
        StDone
    } state_e;

    localparam int unsigned DEFAULT_LINE_WORDS = 4;

    // Byte-offset bits covered by one line: word offset plus the 2 byte bits.
    function automatic int unsigned offset_bits(input int unsigned line_words);
        return $clog2(line_words) + 2;
    endfunction

    localparam int unsigned OFFSET_BITS = offset_bits(DEFAULT_LINE_WORDS);

    // Word index of the first word of the line containing a byte address.
    function automatic logic [31:0] line_base_word(input logic [31:0] addr,
                                                   input int unsigned off_bits);
        return (addr >> off_bits) << (off_bits - 2);
    endfunction

endpackage

// File: rtl/line_memory_responder_if.sv
// Line request bus between the data cache (master) and main memory (slave).
// One request in flight; beats are streamed with word_valid/word_idx.
interface line_memory_responder_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LINE_WORDS = 4
) ();
    localparam int unsigned IW = $clog2(LINE_WORDS);

    logic                  req;
    logic                  we;
    logic [31:0]           addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic [IW-1:0]         word_idx;
    logic                  word_valid;
    logic                  ack;
    logic                  busy;

    modport master (
        output req, we, addr, wdata,
        input  rdata, word_idx, word_valid, ack, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, word_idx, word_valid, ack, busy
    );
endinterface

// File: rtl/mem_word_array.sv
// Single-port word RAM: asynchronous read, synchronous write.
// Each word powers up holding its own byte address; reset does not touch it.
module mem_word_array #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
    input  logic                  i_clock,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    localparam int unsigned BITS = DEPTH_WORDS * DATA_WIDTH;

    function automatic logic [BITS-1:0] init_image();
        logic [BITS-1:0] img;
        for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
            img[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(4 * i);
        end
        return img;
    endfunction

    // Flat storage so the time-zero image can be given as a declaration initializer.
    logic [BITS-1:0] r_mem = init_image();

    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[32'(i_addr) * DATA_WIDTH +: DATA_WIDTH] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[32'(i_addr) * DATA_WIDTH +: DATA_WIDTH];
endmodule

// File: rtl/line_memory_responder.sv
// Main-memory responder for cache line refills and write-backs.
// Accepts one line request, waits LATENCY cycles, streams LINE_WORDS beats, then acks.
module line_memory_responder
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned LINE_WORDS  = 4,
    parameter int unsigned LATENCY     = 8,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input logic                     i_clock,
    input logic                     i_reset,
    line_memory_responder_if.slave  io_bus
);
    localparam int unsigned IW  = $clog2(LINE_WORDS);
    localparam int unsigned AW  = $clog2(DEPTH_WORDS);
    localparam int unsigned OFF = offset_bits(LINE_WORDS);
    localparam int unsigned CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e                r_state, w_state_d;
    logic [AW-1:0]         r_base, w_base_d;
    logic                  r_we, w_we_d;
    logic [CW-1:0]         r_cnt, w_cnt_d;
    logic [IW-1:0]         r_idx, w_idx_d;
    logic [DATA_WIDTH-1:0] r_rdata, w_rdata_d;
    logic                  r_valid, w_valid_d;
    logic                  r_ack, w_ack_d;
    logic                  r_busy, w_busy_d;

    logic [AW-1:0]         w_line_base;
    logic                  w_wr_beat;
    logic                  w_mem_we;
    logic [AW-1:0]         w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    assign w_line_base = AW'(line_base_word(io_bus.addr, OFF));

    // The single port writes the current beat on write-backs and otherwise
    // looks ahead to the next beat's word so rdata can be registered.
    assign w_wr_beat  = (r_state == StBurst) && r_we;
    assign w_mem_we   = w_wr_beat && !i_reset;
    assign w_mem_addr = w_wr_beat ? r_base + AW'(r_idx) : w_base_d + AW'(w_idx_d);

    mem_word_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .i_clock (i_clock),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (io_bus.wdata),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_base  <= '0;
            r_we    <= 1'b0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rdata <= '0;
            r_valid <= 1'b0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_base  <= w_base_d;
            r_we    <= w_we_d;
            r_cnt   <= w_cnt_d;
            r_idx   <= w_idx_d;
            r_rdata <= w_rdata_d;
            r_valid <= w_valid_d;
            r_ack   <= w_ack_d;
            r_busy  <= w_busy_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_base_d  = r_base;
        w_we_d    = r_we;
        w_cnt_d   = r_cnt;
        w_idx_d   = r_idx;
        unique case (r_state)
            StIdle: begin
                if (io_bus.req) begin
                    w_base_d = w_line_base;
                    w_we_d   = io_bus.we;
                    w_idx_d  = '0;
                    if (LATENCY != 0) begin
                        w_state_d = StWait;
                        w_cnt_d   = CW'(LATENCY - 1);
                    end else begin
                        w_state_d = StBurst;
                    end
                end
            end
            StWait: begin
                if (r_cnt == '0) begin
                    w_state_d = StBurst;
                    w_idx_d   = '0;
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                end
            end
            StBurst: begin
                if (r_idx == IW'(LINE_WORDS - 1)) begin
                    w_state_d = StDone;
                    w_idx_d   = '0;
                end else begin
                    w_idx_d = r_idx + 1'b1;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Outputs are registered copies of what the next state presents.
    always_comb begin
        w_valid_d = (w_state_d == StBurst);
        w_ack_d   = (w_state_d == StDone);
        w_busy_d  = (w_state_d != StIdle);
        w_rdata_d = r_rdata;
        if ((w_state_d == StBurst) && !w_we_d) begin
            w_rdata_d = w_mem_rdata;
        end
    end

    assign io_bus.rdata      = r_rdata;
    assign io_bus.word_idx   = r_idx;
    assign io_bus.word_valid = r_valid;
    assign io_bus.ack        = r_ack;
    assign io_bus.busy       = r_busy;
endmodule
